// File: rtl/sdram_read_pkg.sv
// Shared types and default widths for the SDRAM read streamer.
package sdram_read_pkg;
  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, WAIT_DONE} rd_state_e;
endpackage

// File: rtl/sdram_read_skid_fifo.sv
// Two-entry output FIFO; head word is shown combinationally on dout.
module sdram_read_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         not_empty
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout      = mem[rd_ptr];
  assign full      = (cnt == 2'd2);
  assign not_empty = (cnt != 2'd0);
endmodule

// File: rtl/sdram_read_streamer.sv
// Splits a byte region into bounded SDRAM read requests and streams the words out.
// Optional running checksum output: define SDRAM_READ_STREAMER_CKSUM_EN.
module sdram_read_streamer
  import sdram_read_pkg::*;
#(
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int DATA_W      = SDRAM_DATA_W,
  parameter int CHUNK_BYTES = 512
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_length,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              ctl_fixed_location,
  output logic [ADDR_W-1:0] ctl_read_base,
  output logic [ADDR_W-1:0] ctl_read_length,
  output logic              ctl_go,
  input  logic              ctl_done,
  output logic              usr_read_buffer,
  input  logic [DATA_W-1:0] usr_buffer_output_data,
  input  logic              usr_data_available,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef SDRAM_READ_STREAMER_CKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);
  localparam int WL_W = $clog2(CHUNK_BYTES / 2) + 1;
  localparam logic [ADDR_W-1:0] CHUNK = ADDR_W'(CHUNK_BYTES);

  rd_state_e         state, nxt_state;
  logic [ADDR_W-1:0] cur_addr, remaining, base_q, len_q, chunk_q;
  logic              loop_q, stop_pending;
  logic [WL_W-1:0]   words_left;
  logic [ADDR_W-1:0] adv_addr, adv_rem, ld_addr, ld_rem, ld_chunk;
  logic              fifo_full, fifo_ne, push_last, pop_out;

  assign adv_addr = cur_addr + chunk_q;
  assign adv_rem  = remaining - chunk_q;

  // Address/length the next ISSUE will use: fresh config, next chunk, or loop restart.
  always_comb begin
    ld_addr = adv_addr;
    ld_rem  = adv_rem;
    if (state == IDLE) begin
      ld_addr = cfg_base & ~ADDR_W'(1);
      ld_rem  = cfg_length;
    end else if (adv_rem == '0 && loop_q) begin
      ld_addr = base_q;
      ld_rem  = len_q;
    end
    ld_chunk = (ld_rem > CHUNK) ? CHUNK : ld_rem;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:      if (start) nxt_state = ISSUE;
      ISSUE:     nxt_state = STREAM;
      STREAM:    if (usr_read_buffer && words_left == WL_W'(1)) nxt_state = WAIT_DONE;
      WAIT_DONE: if (ctl_done) begin
        if (stop_pending)        nxt_state = IDLE;
        else if (adv_rem != '0)  nxt_state = ISSUE;
        else if (loop_q)         nxt_state = ISSUE;
        else                     nxt_state = IDLE;
      end
      default:   nxt_state = IDLE;
    endcase
  end

  always_comb begin
    ctl_go          = (state == ISSUE);
    usr_read_buffer = (state == STREAM) && usr_data_available && !fifo_full &&
                      (words_left != '0);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cur_addr        <= '0;
      remaining       <= '0;
      base_q          <= '0;
      len_q           <= '0;
      chunk_q         <= '0;
      loop_q          <= 1'b0;
      stop_pending    <= 1'b0;
      words_left      <= '0;
      ctl_read_base   <= '0;
      ctl_read_length <= '0;
    end else begin
      if (state == IDLE && start) begin
        base_q       <= cfg_base & ~ADDR_W'(1);
        len_q        <= cfg_length;
        loop_q       <= cfg_loop;
        stop_pending <= 1'b0;
      end else if (state != IDLE && stop) begin
        stop_pending <= 1'b1;
      end
      if (nxt_state == ISSUE && state != ISSUE) begin
        cur_addr        <= ld_addr;
        remaining       <= ld_rem;
        chunk_q         <= ld_chunk;
        ctl_read_base   <= ld_addr;
        ctl_read_length <= ld_chunk;
      end
      if (state == ISSUE)       words_left <= WL_W'(chunk_q >> 1);
      else if (usr_read_buffer) words_left <= words_left - WL_W'(1);
    end
  end

  // Final word of the region pass: last chunk of the pass, last word of that chunk.
  assign push_last = (remaining == chunk_q) && (words_left == WL_W'(1));
  assign pop_out   = out_valid && out_ready;

  sdram_read_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (usr_read_buffer),
    .din       ({push_last, usr_buffer_output_data}),
    .pop       (pop_out),
    .dout      ({out_last, out_data}),
    .full      (fifo_full),
    .not_empty (fifo_ne)
  );

  assign out_valid          = fifo_ne;
  assign busy               = (state != IDLE) || fifo_ne;
  assign ctl_fixed_location = 1'b0;

`ifdef SDRAM_READ_STREAMER_CKSUM_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)              checksum <= 16'h0;
    else if (state == IDLE && start) checksum <= 16'h0;
    else if (pop_out)                checksum <= checksum + out_data[15:0];
  end
`endif
endmodule

// File: tb/tb_sdram_read_streamer.sv
// Self-checking bench: SDRAM read master model, output scoreboard, region vector table.
module tb_sdram_read_streamer;
  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic [AW-1:0] cfg_base = '0, cfg_length = '0;
  logic          cfg_loop = 1'b0, start = 1'b0, stop = 1'b0, out_ready = 1'b1;
  logic          busy, ctl_fixed_location, ctl_go, ctl_done, usr_read_buffer;
  logic [AW-1:0] ctl_read_base, ctl_read_length;
  logic [DW-1:0] usr_buffer_output_data, out_data;
  logic          usr_data_available, out_valid, out_last;
`ifdef SDRAM_READ_STREAMER_CKSUM_EN
  logic [15:0]   checksum;
`endif

  always #5 clk_clk = ~clk_clk;

  sdram_read_streamer dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cfg_base(cfg_base), .cfg_length(cfg_length), .cfg_loop(cfg_loop),
    .start(start), .stop(stop), .busy(busy),
    .ctl_fixed_location(ctl_fixed_location), .ctl_read_base(ctl_read_base),
    .ctl_read_length(ctl_read_length), .ctl_go(ctl_go), .ctl_done(ctl_done),
    .usr_read_buffer(usr_read_buffer), .usr_buffer_output_data(usr_buffer_output_data),
    .usr_data_available(usr_data_available),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef SDRAM_READ_STREAMER_CKSUM_EN
    , .checksum(checksum)
`endif
  );

  typedef struct packed { logic last; logic [DW-1:0] d; } exp_t;
  typedef struct packed { logic [AW-1:0] b; logic [AW-1:0] l; } go_t;
  typedef struct {
    logic [AW-1:0]       base, len;
    int                  ngo;
    logic [2:0][AW-1:0]  gb, gl;
  } vec_t;

  exp_t exp_q[$];
  go_t  go_q[$];
  vec_t vt[5];
  int   compared = 0, mismatched = 0;
  int   acc = 0, lastcnt = 0;
  int   pass_words = 1;
  logic [DW-1:0] seed_val = 16'h1, step_val = 16'h1;

  // Master model: show-ahead buffer with random availability gaps.
  int            pending, dly, wcnt = 0;
  logic          gate;
  logic [DW-1:0] seq = 16'h1;
  assign usr_data_available     = (pending != 0) && gate;
  assign usr_buffer_output_data = seq;

  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pending  <= 0;
      ctl_done <= 1'b1;
      dly      <= 0;
      gate     <= 1'b0;
    end else begin
      gate <= ($urandom_range(0, 3) != 0);
      if (start) begin
        seq  <= seed_val;
        wcnt <= 0;
      end else if (ctl_go) begin
        pending  <= int'(ctl_read_length) / 2;
        ctl_done <= 1'b0;
        dly      <= 0;
      end else if (usr_read_buffer && usr_data_available) begin
        exp_q.push_back({((wcnt + 1) % pass_words) == 0, seq});
        seq     <= seq + step_val;
        wcnt    <= wcnt + 1;
        pending <= pending - 1;
      end else if (pending == 0 && !ctl_done) begin
        if (dly == 2) ctl_done <= 1'b1;
        dly <= dly + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard, hold stability, full-FIFO pop gating.
  logic          hold_prev = 1'b0;
  logic [DW:0]   hold_val = '0;
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      exp_q.delete();
      hold_prev <= 1'b0;
    end else begin
      if (ctl_go) go_q.push_back({ctl_read_base, ctl_read_length});
      if (exp_q.size() >= 2) chk("full_gate", usr_read_buffer, 0);
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_last, out_data}, hold_val);
      end
      hold_prev <= out_valid && !out_ready;
      hold_val  <= {out_last, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", {out_last, out_data}, 17'h1ffff);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.last);
        end
        acc     <= acc + 1;
        lastcnt <= lastcnt + (out_last ? 1 : 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  int acc0, last0, go0;

  task automatic begin_region(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic lp,
                              input logic [DW-1:0] sd, input logic [DW-1:0] st);
    cfg_base = b; cfg_length = l; cfg_loop = lp;
    pass_words = int'(l) / 2; seed_val = sd; step_val = st;
    acc0 = acc; last0 = lastcnt; go0 = go_q.size();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_latency_go", ctl_go, 1);
    chk("fixed_location", ctl_fixed_location, 0);
  endtask

  task automatic wait_idle(input int budget, input bit bp);
    int  n = 0;
    bit  bp_done = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
      if (bp && !bp_done && (acc - acc0) >= 5) begin
        out_ready = 1'b0;
        repeat (10) cyc();
        n += 10;
        chk("bp_valid_held", out_valid, 1);
        chk("bp_fifo_two", exp_q.size(), 2);
        chk("bp_pop_low", usr_read_buffer, 0);
        out_ready = 1'b1;
        bp_done = 1;
      end
    end
    chk("idle_within_budget", busy, 0);
  endtask

  task automatic end_region(input int nwords, input int nlast);
    cyc();
    chk("word_count", acc - acc0, nwords);
    chk("last_count", lastcnt - last0, nlast);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic run_vec(input int i);
    begin_region(vt[i].base, vt[i].len, 1'b0, 16'h1, 16'h1);
    wait_idle(4000, 0);
    end_region(int'(vt[i].len) / 2, 1);
    chk("go_count", go_q.size() - go0, vt[i].ngo);
    for (int k = 0; k < vt[i].ngo; k++)
      if (go0 + k < go_q.size()) begin
        chk("go_base", go_q[go0 + k].b, vt[i].gb[k]);
        chk("go_len", go_q[go0 + k].l, vt[i].gl[k]);
      end
  endtask

  task automatic set_vec(input int i, input logic [AW-1:0] b, input logic [AW-1:0] l, input int n,
                         input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                         input logic [AW-1:0] b1, input logic [AW-1:0] l1,
                         input logic [AW-1:0] b2, input logic [AW-1:0] l2);
    vt[i].base = b; vt[i].len = l; vt[i].ngo = n;
    vt[i].gb[0] = b0; vt[i].gl[0] = l0;
    vt[i].gb[1] = b1; vt[i].gl[1] = l1;
    vt[i].gb[2] = b2; vt[i].gl[2] = l2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gos, n;
    set_vec(0, 25'h100,     25'd8,    1, 25'h100,     25'd8,   '0,      '0,     '0,      '0);
    set_vec(1, 25'h0,       25'd1100, 3, 25'h0,       25'd512, 25'h200, 25'd512, 25'h400, 25'd76);
    set_vec(2, 25'h1FFFE00, 25'd1024, 2, 25'h1FFFE00, 25'd512, 25'h0,   25'd512, '0,      '0);
    set_vec(3, 25'h101,     25'd2,    1, 25'h100,     25'd2,   '0,      '0,     '0,      '0);
    set_vec(4, 25'h40,      25'd514,  2, 25'h40,      25'd512, 25'h240, 25'd2,   '0,      '0);

    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_go", ctl_go, 0);
    chk("rst_base", ctl_read_base, 0);
    chk("rst_len", ctl_read_length, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pop", usr_read_buffer, 0);
    reset_reset_n = 1'b1;
    repeat (2) cyc();

    for (int i = 0; i < 5; i++) run_vec(i);

    // Backpressure mid-stream.
    begin_region(25'h800, 25'd40, 1'b0, 16'h1, 16'h1);
    wait_idle(2000, 1);
    end_region(20, 1);
    chk("bp_go_count", go_q.size() - go0, 1);

    // Loop with stop during the third pass.
    begin_region(25'h300, 25'd4, 1'b1, 16'h1, 16'h1);
    gos = 1; n = 0;
    while (gos < 3 && n < 500) begin
      cyc();
      n++;
      if (ctl_go) gos++;
    end
    chk("loop_third_go", gos, 3);
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    wait_idle(500, 0);
    end_region(6, 3);
    chk("loop_go_count", go_q.size() - go0, 3);
    for (int k = 0; k < 3; k++)
      if (go0 + k < go_q.size()) begin
        chk("loop_go_base", go_q[go0 + k].b, 25'h300);
        chk("loop_go_len", go_q[go0 + k].l, 25'd4);
      end

    // Reset during STREAM, then a fresh short region.
    begin_region(25'h100, 25'd40, 1'b0, 16'h1, 16'h1);
    repeat (4) cyc();
    chk("pre_reset_busy", busy, 1);
    reset_reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_go", ctl_go, 0);
    chk("mid_rst_base", ctl_read_base, 0);
    chk("mid_rst_len", ctl_read_length, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_pop", usr_read_buffer, 0);
    repeat (2) cyc();
    reset_reset_n = 1'b1;
    repeat (2) cyc();
    run_vec(0);

`ifdef SDRAM_READ_STREAMER_CKSUM_EN
    begin_region(25'h0, 25'd4, 1'b0, 16'hFFFF, 16'h3);
    chk("cksum_cleared", checksum, 0);
    wait_idle(500, 0);
    end_region(2, 1);
    chk("checksum", checksum, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sdram_read_streamer.md
# sdram_read_streamer

Sequencer and stream adapter directly downstream of the SDRAM read master in the `system` block. It splits a byte region into bounded read requests on the master's control port. It pops returned words from the master's user port and presents them as a valid/ready stream with last-word marking and optional looping.

## Interface
- `ADDR_W`, 25, byte address and length width; matches master control port.
- `DATA_W`, 16, word width; matches master user port.
- `CHUNK_BYTES`, 512, maximum bytes per read request; power of two, at least 2.
- `clk_clk`  in  1  sole clock; master and SDRAM logic are in this domain.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `cfg_base`  in  ADDR_W  region start byte address; bit 0 is ignored.
- `cfg_length`  in  ADDR_W  region length in bytes; even and nonzero.
- `cfg_loop`  in  1  on region end, restart at `cfg_base`.
- `start`  in  1  single-cycle request; captures `cfg_*`.
- `stop`  in  1  request stop at next chunk boundary.
- `busy`  out  1  sequencer active or output FIFO non-empty.
- `ctl_fixed_location`  out  1  tied 0.
- `ctl_read_base`  out  ADDR_W  chunk start address.
- `ctl_read_length`  out  ADDR_W  chunk length in bytes.
- `ctl_go`  out  1  one-cycle launch pulse.
- `ctl_done`  in  1  master idle/complete.
- `usr_read_buffer`  out  1  pop acknowledge (show-ahead).
- `usr_buffer_output_data`  in  DATA_W  head word.
- `usr_data_available`  in  1  head word valid.
- `out_data`  out  DATA_W  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  word is the final word of the region pass.
- `checksum`  out  16  running sum; present only with `SDRAM_READ_STREAMER_CKSUM_EN`.

## Operation
- **States:** IDLE, ISSUE, STREAM, WAIT_DONE.
- **IDLE:**
  - On `start`: latch base, length and loop into `cur_addr`, `remaining` and `loop_q`.
  - Clear `stop_pending`, then go to ISSUE.
  - `start` while not IDLE is ignored.
- **ISSUE (1 cycle):**
  - `chunk = min(CHUNK_BYTES, remaining)`.
  - Drive `ctl_read_base = cur_addr` and `ctl_read_length = chunk`; both are held registered until the next ISSUE.
  - `ctl_go` = 1 for this cycle only.
  - Load `words_left = chunk/2`, then go to STREAM.
- **STREAM:**
  - `usr_read_buffer = usr_data_available & !fifo_full & (words_left != 0)`.
  - Each pop writes `usr_buffer_output_data` into the FIFO and decrements `words_left`.
  - When `words_left` reaches 0, go to WAIT_DONE.
- **WAIT_DONE:**
  - Wait for `ctl_done = 1`. `ctl_done` is not sampled in the cycle after `ctl_go`.
  - Then `cur_addr += chunk` (mod 2^ADDR_W) and `remaining -= chunk`.
  - If `stop_pending`, go to IDLE.
  - Else if `remaining != 0`, go to ISSUE.
  - Else if `loop_q`, reload `cur_addr`/`remaining` from the latched config and go to ISSUE.
  - Else go to IDLE.
- **Stop:**
  - `stop` in any non-IDLE state sets `stop_pending`.
  - The current chunk always completes; no words are dropped.
- **Output FIFO:**
  - 2 entries.
  - A word is tagged last when popped with `remaining == chunk` and `words_left == 1`.
  - Head is presented on `out_data`/`out_valid`/`out_last`.
  - Head is removed on `out_valid & out_ready`.
  - Simultaneous push and pop when full is not allowed: the pop is gated by `!fifo_full`, which is evaluated before this cycle's pop.
- **busy** = (state != IDLE) | fifo_not_empty.

## Timing
- **Reset values:** every output is 0, state is IDLE and the FIFO is empty. Asserting reset mid-transfer returns to this immediately; the master's in-flight request is abandoned.
- **Start latency:** `start` sampled at edge N gives `ctl_go` high in cycle N+1.
- **Pop-to-output latency:** a word popped at edge M is on `out_valid` in cycle M+1.
- **Throughput:** 1 word per cycle sustained while `out_ready` = 1 and data is available.
- **Inter-chunk gap:** at least 2 cycles (WAIT_DONE, then ISSUE).
- **Output hold:** `out_data` and `out_last` are stable while `out_valid & !out_ready`.

## Configuration
- `SDRAM_READ_STREAMER_CKSUM_EN` defined:
  - `checksum` port exists.
  - Accumulates the 16-bit sum mod 2^16 of `out_data[15:0]` on each `out_valid & out_ready`.
  - Cleared to 0 on accepted `start` and on reset.
  - Continues accumulating across loop passes.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

## Structure
- **Package `sdram_read_pkg`:**
  - State enum (IDLE, ISSUE, STREAM, WAIT_DONE).
  - `SDRAM_ADDR_W` = 25.
  - `SDRAM_DATA_W` = 16.
- **Sub-module `sdram_read_skid_fifo`:** the 2-entry FIFO, width DATA_W+1 (data plus last flag).

## Test plan
- **Single short region:** `cfg_base`=0x100, `cfg_length`=8, model returns 0x0001..0x0004, `out_ready`=1.
  - Expect exactly one `ctl_go` with base 0x100 and length 8.
  - Expect outputs 1, 2, 3, 4 with `out_last` on 4; `busy` falls after the last word is accepted.
- **Multi-chunk region:** `cfg_length`=1100, base 0.
  - Expect three `ctl_go` pulses: (0x000, 512), (0x200, 512), (0x400, 76).
  - Expect 550 words in order, with `out_last` only on word 550.
- **Backpressure:** `out_ready` = 0 for 10 cycles mid-stream.
  - `usr_read_buffer` stays low once the FIFO holds 2 words.
  - No word is lost or duplicated; `out_data` is held stable throughout.
- **Loop and stop:** `cfg_loop`=1, `cfg_length`=4.
  - `ctl_go` repeats with base = `cfg_base`.
  - `stop` mid-STREAM: the chunk finishes, no further `ctl_go` is issued, `busy` falls.
- **Reset mid-transfer:** `reset_reset_n` low during STREAM.
  - All outputs are 0, the FIFO is empty and `busy` = 0.
  - A new `start` after release behaves like the single-short-region case.
- **Checksum (macro defined):** words 0xFFFF and 0x0002 accepted; expect `checksum` = 0x0001.
